otter_lsu_split: RTL
====================

OTTER_LSU_SPLIT -- requirements
Module: otter_lsu_split

Interface
REQ-001 The module SHALL have parameter IO_BASE, default 32'h11000000, the lowest address of the memory-mapped IO region.
REQ-002 The module SHALL have the following ports:
- CLK  in  1  rising-edge clock, shared with the memory
- RST_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  1  pipeline request strobe
- REQ_READY  out  1  request accepted when high with REQ_VALID
- REQ_WE  in  1  1 = store, 0 = load
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  store data, right-justified
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- REQ_SIGN  in  1  1 = zero-extend (unsigned load)
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  32  load result, extended
- RSP_ERR  out  1  request rejected, valid with RSP_VALID
- MEM_ADDR2  out  32  data-port address
- MEM_DIN2  out  32  data-port write data
- MEM_WRITE2  out  1  data-port write strobe
- MEM_READ2  out  1  data-port read strobe
- MEM_SIZE  out  2  data-port size
- MEM_SIGN  out  1  data-port sign
- MEM_DOUT2  in  32  data-port read data, valid one cycle after MEM_READ2
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The module SHALL be the initiator for the data port. It SHALL split accesses the memory cannot perform in one word: half at offset 3; word at offset 1, 2 or 3.
REQ-005 REQ_READY SHALL be high only in IDLE. An accept (REQ_VALID&&REQ_READY) at cycle T SHALL register all REQ_* fields.
REQ-006 The FSM SHALL have these states: IDLE, ISSUE, RD_LO, RD_HI, CAP, WR_BYTE, RESP. RESP SHALL last exactly one cycle, assert RSP_VALID, and then go to IDLE.
REQ-007 The module SHALL send a request to RESP at T+1 with RSP_ERR=1 and no MEM strobe when any of these holds:
- REQ_SIZE=3
- a split access with REQ_ADDR>=IO_BASE
- a split access whose word-aligned address+4 is >=IO_BASE while the aligned address is <IO_BASE
REQ-008 For a fitting access (one word), ISSUE at T+1 SHALL drive REQ_ADDR, REQ_WDATA, REQ_SIZE and REQ_SIGN unchanged with one MEM_READ2 or MEM_WRITE2 pulse.
- load: CAP at T+2 registers MEM_DOUT2 into RSP_RDATA; RESP at T+3
- store: RESP at T+2
REQ-009 A split load SHALL proceed as follows:
- RD_LO at T+1 reads {A[31:2],2'b00} with MEM_SIZE=2, MEM_SIGN=0
- RD_HI at T+2 reads aligned+4 (mod 2^32) and captures the low word
- CAP at T+3 captures the high word and loads the merged result
- RESP at T+4
REQ-010 Merge SHALL compute ({hi,lo} >> 8*A[1:0]) truncated to 16 or 32 bits. Halfwords SHALL be sign-extended from bit 15 when REQ_SIGN=0 and zero-extended otherwise.
REQ-011 A split store SHALL issue N sequential byte writes in WR_BYTE, N=2 (half) or 4 (word), at cycles T+1..T+N.
- byte i: MEM_ADDR2=A+i, MEM_SIZE=0, MEM_DIN2={24'b0, REQ_WDATA[8i+7:8i]}
- a 2-bit counter SHALL track i
- RESP at T+N+1
REQ-012 Outside ISSUE, RD_LO, RD_HI and WR_BYTE, MEM_READ2 and MEM_WRITE2 SHALL be 0. MEM_ADDR2 and MEM_DIN2 SHALL hold their last values.
REQ-013 RSP_RDATA SHALL hold its value until the next CAP. It SHALL be 0 after a store or an error response.
REQ-014 Aligned IO-region accesses SHALL follow REQ-008 unchanged.
REQ-015 REQ_VALID outside IDLE SHALL be ignored.

Reset
REQ-016 On RST_N=0, the module SHALL immediately, without a clock:
- enter IDLE
- set all outputs and registers to 0 except REQ_READY=1
REQ-017 Reset mid-operation SHALL abort the access with no RSP_VALID. Bytes already written SHALL remain written.

Structure
REQ-018 Package otter_lsu_pkg SHALL hold the state enum, the size encodings SZ_BYTE/SZ_HALF/SZ_WORD, and the IO_BASE default.
REQ-019 Alignment, merge and extension SHALL live in combinational sub-module otter_lsu_merge, instantiated once.

Verification
REQ-020 Memory preload: 0x100=0x44332211, 0x104=0x887766A5. The bench SHALL cover:
- lw 0x100 -> one MEM_READ2 at T+1; RSP_VALID at T+3; RSP_RDATA=0x44332211
- lw 0x101 -> reads 0x100 (T+1) and 0x104 (T+2); RSP at T+4; RSP_RDATA=0xA5443322
- lh 0x103 signed -> 0xFFFFA544; lhu 0x103 -> 0x0000A544; RSP at T+4
- sw 0x102 data 0xDDCCBBAA -> byte writes AA, BB, CC, DD at 0x102..0x105 on T+1..T+4; RSP at T+5; lw 0x100 then returns 0xBBAA2211
- REQ_SIZE=3, or lw 0x11000001 -> RSP_ERR=1 at T+1; no MEM strobes
- RST_N low during RD_HI -> strobes drop the same cycle; no RSP_VALID; REQ_READY=1 after release

Source files
------------

// File: rtl/otter_lsu_pkg.sv
// Shared definitions for the OTTER load/store splitter: FSM states,
// access-size encodings and the default base of the memory-mapped IO region.
package otter_lsu_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_RD_LO   = 3'd2,
        ST_RD_HI   = 3'd3,
        ST_CAP     = 3'd4,
        ST_WR_BYTE = 3'd5,
        ST_RESP    = 3'd6
    } lsu_state_e;

    // Index of the last byte written by a split store (half: 2 bytes, word: 4).
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        return (size == SZ_HALF) ? 2'd1 : 2'd3;
    endfunction

endpackage

// File: rtl/otter_lsu_merge.sv
// Combinational helper: classifies an incoming request (split / rejected)
// and reassembles a split load from its low and high aligned words.
module otter_lsu_merge
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    output logic [31:0] req_aligned,
    output logic        req_split,
    output logic        req_err,
    input  logic [1:0]  mrg_off,
    input  logic [1:0]  mrg_size,
    input  logic        mrg_sign,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [31:0] mrg_data
);

    logic [31:0] aligned_plus4;
    logic [31:0] shifted;

    assign req_aligned   = {req_addr[31:2], 2'b00};
    assign aligned_plus4 = req_aligned + 32'd4;

    // A split access would touch two memory words; one crossing into (or
    // lying inside) the IO region cannot be broken up safely and is rejected.
    always_comb begin
        req_split = ((req_size == SZ_HALF) && (req_addr[1:0] == 2'd3)) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'd0));
        req_err   = (req_size == SZ_ILLEGAL) ||
                    (req_split && (req_addr >= IO_BASE)) ||
                    (req_split && (req_aligned < IO_BASE) && (aligned_plus4 >= IO_BASE));
    end

    assign shifted = 32'({hi_word, lo_word} >> {mrg_off, 3'b000});

    // Truncate the shifted pair to the access size; REQ_SIGN=1 means unsigned.
    always_comb begin
        case (mrg_size)
            SZ_BYTE: mrg_data = mrg_sign ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: mrg_data = mrg_sign ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: mrg_data = shifted;
        endcase
    end

endmodule

// File: rtl/otter_lsu_split.sv
// Load/store unit front end for the OTTER data port: passes fitting accesses
// straight through, splits misaligned loads into two aligned word reads and
// misaligned stores into byte writes, and rejects illegal/IO-crossing ones.
module otter_lsu_split
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    lsu_state_e  state_reg, state_next;
    logic [31:0] addr_reg, wdata_reg, lo_reg, rdata_reg;
    logic [31:0] mem_addr_reg, mem_din_reg;
    logic [1:0]  size_reg, mem_size_reg, cnt_reg;
    logic        sign_reg, we_reg, split_reg, err_reg, mem_sign_reg;

    logic [31:0] req_aligned, mrg_data;
    logic        req_split, req_err;
    logic [1:0]  cnt_inc, last_idx;
    logic [7:0]  wdata_byte [4];

    otter_lsu_merge #(.IO_BASE(IO_BASE)) u_merge (
        .req_addr    (REQ_ADDR),
        .req_size    (REQ_SIZE),
        .req_aligned (req_aligned),
        .req_split   (req_split),
        .req_err     (req_err),
        .mrg_off     (addr_reg[1:0]),
        .mrg_size    (size_reg),
        .mrg_sign    (sign_reg),
        .lo_word     (lo_reg),
        .hi_word     (MEM_DOUT2),
        .mrg_data    (mrg_data)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
            assign wdata_byte[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    assign cnt_inc  = cnt_reg + 2'd1;
    assign last_idx = last_byte_idx(size_reg);

    // Next-state selection; requests are only looked at while idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (req_err)        state_next = ST_RESP;
                    else if (!req_split) state_next = ST_ISSUE;
                    else if (REQ_WE)    state_next = ST_WR_BYTE;
                    else                state_next = ST_RD_LO;
                end
            end
            ST_ISSUE:   state_next = we_reg ? ST_RESP : ST_CAP;
            ST_RD_LO:   state_next = ST_RD_HI;
            ST_RD_HI:   state_next = ST_CAP;
            ST_CAP:     state_next = ST_RESP;
            ST_WR_BYTE: state_next = (cnt_reg == last_idx) ? ST_RESP : ST_WR_BYTE;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Request capture, data-port address/data sequencing and result capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            size_reg     <= '0;
            sign_reg     <= 1'b0;
            we_reg       <= 1'b0;
            split_reg    <= 1'b0;
            err_reg      <= 1'b0;
            cnt_reg      <= '0;
            lo_reg       <= '0;
            rdata_reg    <= '0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
            mem_size_reg <= '0;
            mem_sign_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        addr_reg  <= REQ_ADDR;
                        wdata_reg <= REQ_WDATA;
                        size_reg  <= REQ_SIZE;
                        sign_reg  <= REQ_SIGN;
                        we_reg    <= REQ_WE;
                        split_reg <= req_split;
                        err_reg   <= req_err;
                        cnt_reg   <= '0;
                        if (req_err) begin
                            rdata_reg <= '0;
                        end else if (!req_split) begin
                            mem_addr_reg <= REQ_ADDR;
                            mem_din_reg  <= REQ_WDATA;
                            mem_size_reg <= REQ_SIZE;
                            mem_sign_reg <= REQ_SIGN;
                        end else if (REQ_WE) begin
                            mem_addr_reg <= REQ_ADDR;
                            mem_din_reg  <= {24'h0, REQ_WDATA[7:0]};
                            mem_size_reg <= SZ_BYTE;
                            mem_sign_reg <= 1'b0;
                        end else begin
                            mem_addr_reg <= req_aligned;
                            mem_size_reg <= SZ_WORD;
                            mem_sign_reg <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (we_reg) rdata_reg <= '0;
                end
                ST_RD_LO: mem_addr_reg <= mem_addr_reg + 32'd4;
                ST_RD_HI: lo_reg <= MEM_DOUT2;
                ST_CAP:   rdata_reg <= split_reg ? mrg_data : MEM_DOUT2;
                ST_WR_BYTE: begin
                    if (cnt_reg == last_idx) begin
                        rdata_reg <= '0;
                    end else begin
                        cnt_reg      <= cnt_inc;
                        mem_addr_reg <= addr_reg + {30'd0, cnt_inc};
                        mem_din_reg  <= {24'h0, wdata_byte[cnt_inc]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign REQ_READY  = (state_reg == ST_IDLE);
    assign RSP_VALID  = (state_reg == ST_RESP);
    assign RSP_ERR    = err_reg && (state_reg == ST_RESP);
    assign RSP_RDATA  = rdata_reg;
    assign MEM_READ2  = ((state_reg == ST_ISSUE) && !we_reg) ||
                        (state_reg == ST_RD_LO) || (state_reg == ST_RD_HI);
    assign MEM_WRITE2 = ((state_reg == ST_ISSUE) && we_reg) || (state_reg == ST_WR_BYTE);
    assign MEM_ADDR2  = mem_addr_reg;
    assign MEM_DIN2   = mem_din_reg;
    assign MEM_SIZE   = mem_size_reg;
    assign MEM_SIGN   = mem_sign_reg;

endmodule
